// File: rtl/uart_boot_loader.sv
// ---------------------------------------------------------------------------
// uart_boot_loader: boot-time bus master that downloads a program image over
// the UART, echoes every byte, stores 32-bit words and returns a checksum.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_boot_loader #(
  parameter int          WORDS    = 256,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        cpuclk,
  input  logic        reset,
  input  logic        start,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam logic [31:0] C_ADDR_CON = 32'h4000_0020;
  localparam logic [31:0] C_ADDR_RX  = 32'h4000_001C;
  localparam logic [31:0] C_ADDR_TX  = 32'h4000_0018;
  localparam logic [16:0] C_WORDS    = 17'(WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_RX, S_READ_RX, S_ECHO, S_WAIT_TX, S_DISPATCH,
    S_STORE, S_SEND_SUM, S_SEND_ERR, S_WAIT_FIN, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d, sum_q, sum_d;
  logic [1:0]  hdr_q, hdr_d, lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [15:0] n_q, n_d, wcnt_q, wcnt_d;
  logic        rx_pend_q, rx_pend_d, tx_pend_q, tx_pend_d;
  logic        done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic        rd_q, rd_d, wr_q, wr_d, mem_wr_q, mem_wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] n_full;
  logic        con_rd, rx_seen, tx_seen;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^rdata[31:8];

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    sum_d     = sum_q;
    hdr_d     = hdr_q;
    lane_d    = lane_q;
    word_d    = word_q;
    n_d       = n_q;
    wcnt_d    = wcnt_q;
    done_d    = done_q;
    err_d     = err_q;
    n_full    = {byte_q, n_q[7:0]};
    // Status bits are cleared by the read itself, so every poll result is kept
    con_rd    = rd_q && (addr_q == C_ADDR_CON);
    rx_seen   = rx_pend_q | (con_rd & rdata[3]);
    tx_seen   = tx_pend_q | (con_rd & rdata[2]);
    rx_pend_d = rx_seen;
    tx_pend_d = tx_seen;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_POLL_RX;
          hdr_d     = 2'd0;
          lane_d    = 2'd0;
          sum_d     = 8'h00;
          wcnt_d    = 16'h0000;
          done_d    = 1'b0;
          err_d     = 1'b0;
          rx_pend_d = 1'b0;
          tx_pend_d = 1'b0;
        end
      end
      S_POLL_RX: begin
        if (rx_seen) begin
          rx_pend_d = 1'b0;
          state_d   = S_READ_RX;
        end
      end
      S_READ_RX: begin
        byte_d  = rdata[7:0];
        state_d = S_ECHO;
      end
      S_ECHO: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_seen) begin
          tx_pend_d = 1'b0;
          state_d   = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        case (hdr_q)
          2'd0: begin
            n_d[7:0] = byte_q;
            hdr_d    = 2'd1;
            state_d  = S_POLL_RX;
          end
          2'd1: begin
            n_d[15:8] = byte_q;
            hdr_d     = 2'd2;
            if ({1'b0, n_full} > C_WORDS) begin
              err_d   = 1'b1;
              state_d = S_SEND_ERR;
            end else if (n_full == 16'h0000) begin
              state_d = S_SEND_SUM;
            end else begin
              state_d = S_POLL_RX;
            end
          end
          default: begin
            // Little-endian: the first byte of a word ends up in bits 7:0
            sum_d   = sum_q + byte_q;
            word_d  = {byte_q, word_q[31:8]};
            lane_d  = lane_q + 2'd1;
            state_d = (lane_q == 2'd3) ? S_STORE : S_POLL_RX;
          end
        endcase
      end
      S_STORE: begin
        wcnt_d  = wcnt_q + 16'd1;
        state_d = (wcnt_d == n_q) ? S_SEND_SUM : S_POLL_RX;
      end
      S_SEND_SUM, S_SEND_ERR: state_d = S_WAIT_FIN;
      S_WAIT_FIN: begin
        if (tx_seen) begin
          tx_pend_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered alongside the state they belong to
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = 32'h0;
    wdata_d     = 32'h0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    if (state_d == S_DONE) done_d = 1'b1;

    case (state_d)
      S_POLL_RX, S_WAIT_TX, S_WAIT_FIN: begin
        rd_d   = 1'b1;
        addr_d = C_ADDR_CON;
      end
      S_READ_RX: begin
        rd_d   = 1'b1;
        addr_d = C_ADDR_RX;
      end
      S_ECHO, S_SEND_SUM, S_SEND_ERR: begin
        wr_d    = 1'b1;
        addr_d  = C_ADDR_TX;
        wdata_d = (state_d == S_ECHO)     ? {24'h0, byte_d} :
                  (state_d == S_SEND_SUM) ? {24'h0, sum_d}  : 32'h0000_00EE;
      end
      S_STORE: begin
        mem_wr_d    = 1'b1;
        mem_addr_d  = MEM_BASE + {14'h0, wcnt_q, 2'b00};
        mem_wdata_d = word_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpuclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_q      <= 8'h00;
      sum_q       <= 8'h00;
      hdr_q       <= 2'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'h0;
      n_q         <= 16'h0;
      wcnt_q      <= 16'h0;
      rx_pend_q   <= 1'b0;
      tx_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      sum_q       <= sum_d;
      hdr_q       <= hdr_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      rx_pend_q   <= rx_pend_d;
      tx_pend_q   <= tx_pend_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rd         = rd_q;
  assign wr         = wr_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_boot_loader: UART peripheral + host model driving uart_boot_loader,
// results compared with an image-level reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_boot_loader;

  localparam int          WORDS    = 4;
  localparam logic [31:0] MEM_BASE = 32'h0000_0000;
  localparam logic [31:0] CON      = 32'h4000_0020;
  localparam logic [31:0] RXA      = 32'h4000_001C;
  localparam logic [31:0] TXA      = 32'h4000_0018;
  localparam int          LIMIT    = 3000;

  logic        cpuclk = 1'b0;
  logic        reset, start;
  logic        rd, wr, mem_wr, busy, done, err;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata;
  logic [15:0] word_count;

  uart_boot_loader #(.WORDS(WORDS), .MEM_BASE(MEM_BASE)) dut (
    .cpuclk(cpuclk), .reset(reset), .start(start),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 cpuclk = ~cpuclk;

  // Peripheral state
  logic       rx_ready, tx_done, tx_busy, clr_pend, fast, prev_mem_wr;
  logic [7:0] rx_data;
  int         rx_cnt, tx_cnt, host_idx, cyc;
  int         passed, total;

  logic [7:0]  img[$];
  logic [7:0]  tx_log[$];
  logic [31:0] ma_log[$];
  logic [31:0] md_log[$];
  int          echo_cyc[$];

  always_comb begin
    rdata = 32'h0;
    if (rd && addr == CON) rdata = {27'h0, tx_busy, rx_ready, tx_done, 2'b00};
    else if (rd && addr == RXA) rdata = {24'h0, rx_data};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle of the peripheral and host, observed at the falling edge
  task automatic step();
    @(negedge cpuclk);
    cyc = cyc + 1;
    if (clr_pend) begin
      rx_ready = 1'b0;
      tx_done  = 1'b0;
      clr_pend = 1'b0;
    end
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_busy = 1'b0;
      end
    end
    if (rx_cnt > 0) begin
      rx_cnt = rx_cnt - 1;
      if (rx_cnt == 0 && host_idx < img.size()) begin
        rx_data  = img[host_idx];
        host_idx = host_idx + 1;
        rx_ready = 1'b1;
      end
    end
    check("rd_wr_exclusive", {63'h0, rd & wr}, 64'h0);
    if (rd && addr == CON) clr_pend = 1'b1;
    if (wr) begin
      check("wr_addr", {32'h0, addr}, {32'h0, TXA});
      tx_log.push_back(wdata[7:0]);
      echo_cyc.push_back(cyc);
      tx_busy = 1'b1;
      tx_cnt  = fast ? 1 : int'($urandom_range(1, 6));
      if (host_idx < img.size()) rx_cnt = fast ? 1 : int'($urandom_range(2, 9));
    end
    if (!rd && !wr) check("idle_bus_zero", {addr, wdata}, 64'h0);
    if (mem_wr) begin
      ma_log.push_back(mem_addr);
      md_log.push_back(mem_wdata);
      check("mem_wr_single", {63'h0, prev_mem_wr}, 64'h0);
    end
    prev_mem_wr = mem_wr;
  endtask

  task automatic prep(input logic fast_i);
    tx_log.delete(); ma_log.delete(); md_log.delete(); echo_cyc.delete();
    rx_ready = 1'b0; tx_done = 1'b0; tx_busy = 1'b0; clr_pend = 1'b0;
    rx_cnt = 0; tx_cnt = 0; host_idx = 0; fast = fast_i;
  endtask

  task automatic make_img(input int n);
    img.delete();
    img.push_back(n[7:0]);
    img.push_back(n[15:8]);
    if (n <= WORDS)
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  task automatic download(input logic fast_i, input int extra_start);
    int n;
    prep(fast_i);
    rx_cnt = fast_i ? 3 : int'($urandom_range(2, 8));
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("busy_after_start", {30'h0, busy, rd, addr}, {30'h0, 1'b1, 1'b1, CON});
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      if (n == extra_start) start = 1'b1;
      step();
      start = 1'b0;
      n = n + 1;
    end
    check("done_within_limit", {63'h0, done}, 64'h1);
  endtask

  // Reference: expected echo/checksum bytes and memory words from the image alone
  task automatic check_result(input string tag);
    int          n;
    logic [7:0]  s;
    logic [7:0]  etx[$];
    logic [31:0] ew[$];
    n = int'({img[1], img[0]});
    s = 8'h00;
    if (n > WORDS) begin
      etx.push_back(img[0]);
      etx.push_back(img[1]);
      etx.push_back(8'hEE);
    end else begin
      foreach (img[i]) etx.push_back(img[i]);
      for (int i = 2; i < img.size(); i++) s = s + img[i];
      etx.push_back(s);
      for (int w = 0; w < n; w++)
        ew.push_back({img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
    end
    check({tag, "_tx_len"}, 64'(tx_log.size()), 64'(etx.size()));
    for (int i = 0; i < etx.size() && i < tx_log.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), {56'h0, tx_log[i]}, {56'h0, etx[i]});
    check({tag, "_mem_len"}, 64'(md_log.size()), 64'(ew.size()));
    for (int w = 0; w < ew.size() && w < md_log.size(); w++) begin
      check($sformatf("%s_maddr%0d", tag, w), {32'h0, ma_log[w]}, {32'h0, MEM_BASE + 32'(4 * w)});
      check($sformatf("%s_mdata%0d", tag, w), {32'h0, md_log[w]}, {32'h0, ew[w]});
    end
    check({tag, "_word_count"}, {48'h0, word_count}, (n > WORDS) ? 64'h0 : 64'(n));
    check({tag, "_err"}, {63'h0, err}, (n > WORDS) ? 64'h1 : 64'h0);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    for (int i = 0; i < 3; i++) step();
    check({tag, "_done_sticky"}, {62'h0, done, busy}, 64'h2);
  endtask

  initial begin
    int n;
    logic all_zero;
    passed = 0; total = 0; cyc = 0;
    prev_mem_wr = 1'b0;
    rx_data = 8'h00;
    img.delete();
    prep(1'b0);
    reset = 1'b1; start = 1'b0;
    step(); step();
    check("reset_outputs", {rd, wr, mem_wr, busy, done, err, word_count, addr}, 64'h0);
    check("reset_data", {wdata, mem_addr}, 64'h0);
    check("reset_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    reset = 1'b0;
    step();

    // Directed two-word image, slow serial line
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    download(1'b0, -1);
    check_result("two_words");

    // Same image with RX arriving in the same cycle as the TX-done poll
    download(1'b1, -1);
    for (int i = 0; i + 1 < img.size(); i++)
      check($sformatf("fast_gap%0d", i), 64'(echo_cyc[i+1] - echo_cyc[i]),
            (i >= 2 && (i - 2) % 4 == 3) ? 64'd6 : 64'd5);
    check_result("two_words_fast");

    // Empty image
    img = {8'h00, 8'h00};
    download(1'b0, -1);
    check_result("empty");

    // Length error
    img = {8'h05, 8'h00};
    download(1'b0, -1);
    check_result("too_long");

    // Randomized images, mixed timing
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(0, WORDS + 2));
      if (t == 5) n = 300;
      make_img(n);
      download(1'($urandom_range(0, 1)), -1);
      check_result($sformatf("rand%0d", t));
    end

    // Spurious start while busy
    make_img(WORDS);
    download(1'b0, 40);
    check_result("extra_start");

    // Reset in the middle of a download
    make_img(3);
    prep(1'b0);
    rx_cnt = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (ma_log.size() < 1 && n < LIMIT) begin
      step();
      n = n + 1;
    end
    check("mid_reset_reached_store", 64'(ma_log.size()), 64'h1);
    reset = 1'b1;
    step(); step();
    all_zero = ({rd, wr, mem_wr, busy, done, err, word_count, addr, wdata, mem_addr, mem_wdata} == '0);
    check("mid_reset_outputs", {63'h0, all_zero}, 64'h1);
    reset = 1'b0;
    ma_log.delete();
    for (int i = 0; i < 80; i++) step();
    check("mid_reset_no_mem_wr", 64'(ma_log.size()), 64'h0);
    check("mid_reset_idle", {61'h0, busy, done, err}, 64'h0);

    // Recovers cleanly after the abort
    make_img(2);
    download(1'b0, -1);
    check_result("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
